// File: rtl/sram_master_pkg.sv
// Shared encodings for the SRAM request controller: access sizes, FSM states
// and the default implemented depth.
package sram_master_pkg;
  localparam int unsigned MEM_WORDS_DEF = 16384;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_e;
endpackage

// File: rtl/sram_lane.sv
// Byte/half lane logic: extracts and extends load data from a word, and merges
// sub-word store data into a word for read-modify-write.
module sram_lane import sram_master_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [15:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{addr_lo, 3'b000} +: 8];
    h      = addr_lo[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = word;
    case (size)
      SZ_BYTE: begin
        ext = {{24{sgn & b[7]}}, b};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext = {{16{sgn & h[15]}}, h};
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/sram_master.sv
// Single-outstanding load/store controller for a 32-bit word SRAM with a
// one-cycle registered read; sub-word stores are done as read-modify-write.
module sram_master import sram_master_pkg::*; #(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] ld_ext, st_merged;
  logic        req_bad;

  // One lane instance serves both paths; it always looks at the raw SRAM
  // output, which is only meaningful during RD_WAIT.
  sram_lane u_lane (
    .word   (mem_rdata),
    .addr_lo(addr_q[1:0]),
    .size   (size_q),
    .sgn    (sgn_q),
    .wdata  (wdata_q),
    .ext    (ld_ext),
    .merged (st_merged)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mem_rd_en = (state_q == ST_RD);
  assign mem_wr_en = (state_q == ST_WR);
  assign rsp_valid = (state_q == ST_RESP);
  assign mem_addr  = addr_q[17:2];
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    req_bad = (req_size == 2'd3)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
           || (32'(req_addr[17:2]) >= MEM_WORDS);
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        sgn_d   = req_signed;
        addr_d  = req_addr;
        wdata_d = req_wdata[15:0];
        rdata_d = '0;
        err_d   = req_bad;
        if (req_bad) begin
          state_d = ST_RESP;
        end else if (req_we && req_size == SZ_WORD) begin
          mem_wdata_d = req_wdata;
          state_d     = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (we_q) begin
          mem_wdata_d = st_merged;
          state_d     = ST_WR;
        end else begin
          rdata_d = ld_ext;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_sram_master.sv
// Self-checking bench for sram_master: directed vector table, randomized
// traffic against a byte-level memory model, backpressure and mid-op reset.
module tb_sram_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;

  sram_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, garbage on the bus when not reading.
  logic [31:0] sram [0:16383];
  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr[13:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= sram[mem_addr[13:0]];
    else           mem_rdata <= $urandom;
  end
  always @(posedge clk) if (mem_wr_en) wr_total <= wr_total + 1;

  // Reference memory as a flat byte array (only the low 256 bytes are used).
  logic [7:0] ref_mem [0:255];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [17:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eerr,
                       output int elat, output int enrd, output int enwr);
    int n;
    logic [31:0] v;
    eerr = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
        || (a >= 18'h10000);
    erd = 0; elat = 1; enrd = 0; enwr = 0;
    if (!eerr) begin
      n = 1 << sz;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        enwr = 1;
        enrd = (n < 4) ? 1 : 0;
        elat = (n < 4) ? 4 : 2;
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        erd = v; elat = 3; enrd = 1;
      end
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [17:0] a, input logic [31:0] wd, input int hold,
                      input string nm, output logic [31:0] rd, output logic er,
                      output int lat, output int nrd, output int nwr,
                      output logic [15:0] wa);
    int to;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    to = 0;
    while (!req_ready && to < 20) begin @(negedge clk); to++; end
    if (!req_ready) chk({nm, " accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 18'($urandom); req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; wa = '0;
    do begin
      @(negedge clk); lat++;
      if (mem_rd_en) nrd++;
      if (mem_wr_en) begin nwr++; wa = mem_addr; end
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold_ctl"}, {29'd0, rsp_valid, req_ready, rsp_err}, {29'd0, 1'b1, 1'b0, er});
      chk({nm, " hold_data"}, rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, " ready_after"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [17:0] a, input logic [31:0] wd, input int hold,
                     input string nm);
    logic [31:0] erd, rd;
    logic eerr, er;
    int elat, enrd, enwr, lat, nrd, nwr;
    logic [15:0] wa;
    model(we, sz, sg, a, wd, erd, eerr, elat, enrd, enwr);
    xfer(we, sz, sg, a, wd, hold, nm, rd, er, lat, nrd, nwr, wa);
    chk({nm, " rdata"}, rd, erd);
    chk({nm, " err"}, 32'(er), 32'(eerr));
    chk({nm, " lat"}, lat, elat);
    chk({nm, " nrd"}, nrd, enrd);
    chk({nm, " nwr"}, nwr, enwr);
    if (enwr != 0) chk({nm, " wr_addr"}, 32'(wa), 32'(a[17:2]));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [17:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] erd;
    logic        eerr;
    int          elat, enrd, enwr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, nrd, nwr, mlat, mnrd, mnwr, wr_before;
    logic [15:0] wa;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 18'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 0, 1};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,       5, 32'hDEADBEEF, 1'b0, 3, 1, 0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 18'h11, 32'h000000A5, 0, 32'h0,       1'b0, 4, 1, 1};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,       0, 32'hDEADA5EF, 1'b0, 3, 1, 0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 18'h11, 32'h0,       0, 32'hFFFFFFA5, 1'b0, 3, 1, 0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 18'h11, 32'h0,       0, 32'h000000A5, 1'b0, 3, 1, 0};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 18'h12, 32'h0,       0, 32'hFFFFDEAD, 1'b0, 3, 1, 0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 18'h12, 32'h0,       0, 32'h0000DEAD, 1'b0, 3, 1, 0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 18'h13, 32'h0000BEEF, 0, 32'h0,       1'b1, 1, 0, 0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 18'h12, 32'h0,       0, 32'h0,        1'b1, 1, 0, 0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 18'h10, 32'h0,       0, 32'h0,        1'b1, 1, 0, 0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 18'h10000, 32'h0,    0, 32'h0,        1'b1, 1, 0, 0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,       0, 32'hDEADA5EF, 1'b0, 3, 1, 0};

    // Reset values, observed while reset is held.
    #2;
    chk("rst_ctl", {27'd0, req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 32'h10);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Give every word of the random window a known value.
    for (int w = 0; w < 10; w++) run(1'b1, 2'd2, 1'b0, 18'(w * 4), $urandom, 0, "prefill");

    for (int i = 0; i < 13; i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, mrd, mer, mlat, mnrd, mnwr);
      xfer(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, tbl[i].hold, "vec",
           rd, er, lat, nrd, nwr, wa);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].erd);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d lat", i), lat, tbl[i].elat);
      chk($sformatf("vec%0d nrd", i), nrd, tbl[i].enrd);
      chk($sformatf("vec%0d nwr", i), nwr, tbl[i].enwr);
      if (tbl[i].enwr != 0) chk($sformatf("vec%0d wr_addr", i), 32'(wa), 32'h4);
    end

    for (int i = 0; i < 150; i++) begin
      logic [17:0] a;
      if ($urandom_range(0, 9) == 0) a = 18'($urandom_range(32'h10000, 32'h3FFFF));
      else                           a = 18'($urandom_range(0, 39));
      run(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          int'($urandom_range(0, 2)), "rand");
    end

    // Reset during RD_WAIT of a byte store must not write anything.
    run(1'b1, 2'd2, 1'b0, 18'h20, 32'h11223344, 0, "pre_rst");
    wr_before = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 18'h21; req_wdata = 32'h77;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_strobe", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {27'd0, req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 32'h10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ctl", {30'd0, req_ready, rsp_valid}, 32'd2);
    chk("post_rst_nowrite", wr_total, wr_before);
    run(1'b0, 2'd2, 1'b0, 18'h20, 32'h0, 0, "post_rst_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/sram_master.md
# sram_master

Request-side controller that drives the team's single-port 32-bit word SRAM on behalf of the CPU load/store unit. Accepts byte, halfword and word loads and stores on a valid/ready port and issues SRAM read/write strobes, accounting for the SRAM's one-cycle registered read latency. Performs read-modify-write for sub-word stores, because the SRAM has no byte enables. Returns extended load data or an error on a valid/ready response port, with one request outstanding at a time.

## Interface
- MEM_WORDS, 16384, number of implemented SRAM words; word index ≥ MEM_WORDS is an error
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  18  byte address, little-endian
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned access, reserved size or out-of-range access
- mem_rd_en  out  1  SRAM read strobe
- mem_wr_en  out  1  SRAM write strobe
- mem_addr  out  16  SRAM word index = req_addr[17:2]
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM registered read data, valid the cycle after mem_rd_en

## Operation
- States:
  - IDLE: req_ready=1.
  - RD: mem_rd_en=1.
  - RD_WAIT: captures mem_rdata into the data register.
  - WR: mem_wr_en=1.
  - RESP: rsp_valid=1.
- On a req_valid&&req_ready edge, latch we, size, signed, addr and wdata, then go to:
  - RESP with err=1, if size==3, or the address is misaligned (half with addr[0]=1; word with addr[1:0]≠0), or addr[17:2] ≥ MEM_WORDS. No SRAM strobe is issued.
  - WR for a word store; mem_wdata = req_wdata.
  - RD for loads and sub-word stores.
- RD → RD_WAIT → (load: RESP | sub-word store: WR).
- WR → RESP.
- RESP holds until rsp_ready; on handshake → IDLE.
- Load extraction, on the captured word:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] or [31:16]).
  - Zero-extend, or sign-extend if req_signed. Word loads pass through.
- Store merge: replace the addressed byte or halfword lane of the captured word with req_wdata[7:0] or [15:0]; all other lanes are unchanged.
- mem_* strobes are pure decodes of state. mem_addr and mem_wdata come from registers.
- Only one request is in flight; req_ready=0 outside IDLE.

## Timing
- Reset values: state IDLE. req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: strobes drop asynchronously with rst, no partial write is issued, and any pending response is discarded.
- Latency (cycles from the accept edge to the first rsp_valid cycle):
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- rsp_valid, rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
- req_ready rises in the cycle after the response handshake. There are no back-to-back accepts.
- mem_rdata is sampled only at the end of RD_WAIT. It is ignored in all other states.

## Structure
- Shared package sram_master_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - MEM_WORDS default.
- One combinational sub-module, sram_lane, holds the extraction (load) and merge (store) lane logic, reused by the load and RMW paths.
- The FSM and registers live in sram_master.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10:
  - mem_wr_en pulses 1 cycle with mem_addr=0x0004.
  - Load returns rsp_rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept.
- Byte store 0xA5 at 0x11:
  - Word at 0x10 becomes 0xDEADA5EF; the RMW shows rd pulse, then 1 wait cycle, then wr pulse.
  - Signed byte load at 0x11 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Signed half load at 0x12 → 0xFFFFDEAD; unsigned → 0x0000DEAD.
- Half store at 0x13, word load at 0x12, size=3 request, and address 0x10000 (index 16384):
  - Each returns rsp_err=1, rsp_rdata=0, with no mem_rd_en/mem_wr_en pulse.
  - Word at 0x10 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response:
  - rsp_valid and rsp_rdata stay stable and req_ready=0.
  - After the handshake, req_ready=1 on the next cycle.
- Assert rst while in RD_WAIT of a byte store:
  - mem_wr_en never asserts and the memory word is unchanged.
  - After release, req_ready=1 and rsp_valid=0.
